l2_mem_arbiter: RTL and testbench

- Shares the single L2 SRAM memory port between two requesters: client 0 (I-cache refill) and client 1 (D-cache refill/writeback).
- Sits between the two caches and the L2 block.
- Arbitrates requests round-robin, extends each client tag with a client-ID bit so responses can be routed back, and locks the grant for 4-beat store bursts so line writes are never interleaved.

---
 rtl/l2_mem_arbiter_pkg.sv | 19 +
 rtl/l2_mem_arbiter_if.sv | 59 +++++
 rtl/l2_mem_arbiter_rr_arb2.sv | 30 +++
 rtl/l2_mem_arbiter.sv | 113 +++++++++++
 tb/tb_l2_mem_arbiter.sv | 325 ++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/l2_mem_arbiter_pkg.sv
// Shared definitions for the L2 memory-port arbiter: FSM encoding, request-op
// constants and client-ID width used to extend tags on the L2 side.
package l2_mem_pkg;

  typedef enum logic {
    ARB  = 1'b0,
    LOCK = 1'b1
  } arb_state_e;

  localparam int          RW_BITS        = 2;
  localparam logic [1:0]  RW_LOAD        = 2'b00;
  localparam int          RW_STORE_BIT   = 0;
  localparam int          CLIENT_ID_BITS = 1;

  function automatic logic is_store(input logic [RW_BITS-1:0] rw);
    return rw[RW_STORE_BIT];
  endfunction

endpackage

// File: rtl/l2_mem_arbiter_if.sv
// Request/response bundles for one cache client and for the L2 memory port.
// The arbiter is the slave of each client bundle and the master of the L2 bundle.
interface l2_client_if
  import l2_mem_pkg::*;
#(
  parameter int ADDR_BITS = 12,
  parameter int DATA_BITS = 128,
  parameter int TAG_BITS  = 4
);
  logic                 req_val;
  logic                 req_rdy;
  logic [RW_BITS-1:0]   req_rw;
  logic [ADDR_BITS-1:0] req_addr;
  logic [DATA_BITS-1:0] req_data;
  logic [TAG_BITS-1:0]  req_tag;
  logic                 resp_val;
  logic                 resp_nack;
  logic [DATA_BITS-1:0] resp_data;
  logic [TAG_BITS-1:0]  resp_tag;

  modport master (
    output req_val, req_rw, req_addr, req_data, req_tag,
    input  req_rdy, resp_val, resp_nack, resp_data, resp_tag
  );

  modport slave (
    input  req_val, req_rw, req_addr, req_data, req_tag,
    output req_rdy, resp_val, resp_nack, resp_data, resp_tag
  );
endinterface

interface l2_mem_if
  import l2_mem_pkg::*;
#(
  parameter int ADDR_BITS = 12,
  parameter int DATA_BITS = 128,
  parameter int TAG_BITS  = 5
);
  logic                 req_val;
  logic                 req_rdy;
  logic [RW_BITS-1:0]   req_rw;
  logic [ADDR_BITS-1:0] req_addr;
  logic [DATA_BITS-1:0] req_data;
  logic [TAG_BITS-1:0]  req_tag;
  logic                 resp_val;
  logic                 resp_nack;
  logic [DATA_BITS-1:0] resp_data;
  logic [TAG_BITS-1:0]  resp_tag;

  modport master (
    output req_val, req_rw, req_addr, req_data, req_tag,
    input  req_rdy, resp_val, resp_nack, resp_data, resp_tag
  );

  modport slave (
    input  req_val, req_rw, req_addr, req_data, req_tag,
    output req_rdy, resp_val, resp_nack, resp_data, resp_tag
  );
endinterface

// File: rtl/l2_mem_arbiter_rr_arb2.sv
// Two-input round-robin grant with a last-grant register; the last winner loses
// a tie. Shared with the I/O-port arbiter.
module rr_arb2 (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] req,
  input  logic       advance,
  output logic       grant
);

  logic last_q, last_d;

  // NOTE: every output of this block is assigned on every path, so no latch is inferred.
  always_comb begin
    unique case (req)
      2'b01:   grant = 1'b0;
      2'b10:   grant = 1'b1;
      2'b11:   grant = ~last_q;
      default: grant = last_q;
    endcase
    last_d = advance ? grant : last_q;
  end

  // NOTE: state flops use non-blocking assignment so all registers update together.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) last_q <= 1'b1;
    else        last_q <= last_d;
  end

endmodule

// File: rtl/l2_mem_arbiter.sv
// Shares the L2 port between the I-cache (client 0) and D-cache (client 1):
// round-robin grant, client-ID tag extension, and grant lock for store bursts.
module l2_mem_arbiter
  import l2_mem_pkg::*;
#(
  parameter int ADDR_BITS       = 12,
  parameter int DATA_BITS       = 128,
  parameter int CLIENT_TAG_BITS = 4,
  parameter int MEM_TAG_BITS    = 5,
  parameter int STORE_BEATS     = 4
) (
  input  logic          clk,
  input  logic          reset_n,
  l2_client_if.slave    c0,
  l2_client_if.slave    c1,
  l2_mem_if.master      mem
);

  if (MEM_TAG_BITS != CLIENT_TAG_BITS + CLIENT_ID_BITS) begin : g_bad_tag_bits
    $error("l2_mem_arbiter: MEM_TAG_BITS must equal CLIENT_TAG_BITS+1");
  end
  if (STORE_BEATS < 2 || (STORE_BEATS & (STORE_BEATS - 1)) != 0) begin : g_bad_store_beats
    $error("l2_mem_arbiter: STORE_BEATS must be a power of 2 (>= 2)");
  end

  localparam int               CNT_W     = $clog2(STORE_BEATS);
  localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(STORE_BEATS - 1);

  arb_state_e                 state_q, state_d;
  logic                       lock_owner_q, lock_owner_d;
  logic [CNT_W-1:0]           beat_cnt_q, beat_cnt_d;

  logic                       rr_grant, rr_advance, grant, fire;
  logic [RW_BITS-1:0]         sel_rw;
  logic [ADDR_BITS-1:0]       sel_addr;
  logic [DATA_BITS-1:0]       sel_data;
  logic [CLIENT_TAG_BITS-1:0] sel_tag;

  rr_arb2 u_rr_arb2 (
    .clk     (clk),
    .rst_n   (reset_n),
    .req     ({c1.req_val, c0.req_val}),
    .advance (rr_advance),
    .grant   (rr_grant)
  );

  // While a store burst is in flight the owner keeps the port regardless of the peer.
  assign grant      = (state_q == LOCK) ? lock_owner_q : rr_grant;
  assign rr_advance = fire && (state_q == ARB);

  assign sel_rw   = grant ? c1.req_rw   : c0.req_rw;
  assign sel_addr = grant ? c1.req_addr : c0.req_addr;
  assign sel_data = grant ? c1.req_data : c0.req_data;
  assign sel_tag  = grant ? c1.req_tag  : c0.req_tag;

  assign mem.req_val  = grant ? c1.req_val : c0.req_val;
  assign mem.req_rw   = sel_rw;
  assign mem.req_addr = sel_addr;
  assign mem.req_data = sel_data;
  assign mem.req_tag  = {grant, sel_tag};
  assign c0.req_rdy   = ~grant & mem.req_rdy;
  assign c1.req_rdy   =  grant & mem.req_rdy;
  assign fire         = mem.req_val & mem.req_rdy;

  // Responses are routed purely by the client-ID bit carried in the tag MSB.
  assign c0.resp_val  = mem.resp_val  & ~mem.resp_tag[MEM_TAG_BITS-1];
  assign c1.resp_val  = mem.resp_val  &  mem.resp_tag[MEM_TAG_BITS-1];
  assign c0.resp_nack = mem.resp_nack & ~mem.resp_tag[MEM_TAG_BITS-1];
  assign c1.resp_nack = mem.resp_nack &  mem.resp_tag[MEM_TAG_BITS-1];
  assign c0.resp_tag  = mem.resp_tag[CLIENT_TAG_BITS-1:0];
  assign c1.resp_tag  = mem.resp_tag[CLIENT_TAG_BITS-1:0];
  assign c0.resp_data = mem.resp_data;
  assign c1.resp_data = mem.resp_data;

  always_comb begin
    state_d      = state_q;
    lock_owner_d = lock_owner_q;
    beat_cnt_d   = beat_cnt_q;
    if (fire) begin
      unique case (state_q)
        ARB: begin
          if (is_store(sel_rw)) begin
            state_d      = LOCK;
            lock_owner_d = grant;
            beat_cnt_d   = CNT_W'(1);
          end
        end
        LOCK: begin
          if (beat_cnt_q == LAST_BEAT) begin
            state_d    = ARB;
            beat_cnt_d = '0;
          end else begin
            beat_cnt_d = beat_cnt_q + 1'b1;
          end
        end
        default: state_d = ARB;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= ARB;
      lock_owner_q <= 1'b0;
      beat_cnt_q   <= '0;
    end else begin
      state_q      <= state_d;
      lock_owner_q <= lock_owner_d;
      beat_cnt_q   <= beat_cnt_d;
    end
  end

endmodule

// File: tb/tb_l2_mem_arbiter.sv
// Scoreboard bench for l2_mem_arbiter: a cycle-level reference model predicts
// the presented L2 request, client readies and routed responses.
module tb_l2_mem_arbiter;
  import l2_mem_pkg::*;

  localparam int AB = 12;
  localparam int DB = 128;
  localparam int CT = 4;
  localparam int MT = 5;
  localparam int SB = 4;

  logic clk     = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  l2_client_if #(.ADDR_BITS(AB), .DATA_BITS(DB), .TAG_BITS(CT)) c0_if ();
  l2_client_if #(.ADDR_BITS(AB), .DATA_BITS(DB), .TAG_BITS(CT)) c1_if ();
  l2_mem_if    #(.ADDR_BITS(AB), .DATA_BITS(DB), .TAG_BITS(MT)) mem_if ();

  l2_mem_arbiter #(
    .ADDR_BITS(AB), .DATA_BITS(DB), .CLIENT_TAG_BITS(CT),
    .MEM_TAG_BITS(MT), .STORE_BEATS(SB)
  ) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .c0      (c0_if),
    .c1      (c1_if),
    .mem     (mem_if)
  );

  typedef struct packed {
    logic [1:0]    rw;
    logic [AB-1:0] addr;
    logic [DB-1:0] data;
    logic [CT-1:0] tag;
  } req_t;

  typedef struct packed {
    logic id;
    req_t r;
  } exp_req_t;

  typedef struct packed {
    logic          id;
    logic          nack;
    logic [DB-1:0] data;
    logic [CT-1:0] tag;
  } exp_resp_t;

  typedef struct packed {
    logic          val;
    logic          nack;
    logic [DB-1:0] data;
    logic [MT-1:0] tag;
  } resp_t;

  int n_checks = 0;
  int n_fail   = 0;

  req_t       pend [2][$];
  resp_t      resp_plan [$];
  exp_req_t   exp_req_q [$];
  exp_resp_t  exp_resp_q [$];
  logic [1:0] exp_rdy_q [$];
  bit         gen_en = 1'b0;

  // Reference model: owner of an open burst (-1 if none), beats still owed, last winner.
  int m_owner = -1;
  int m_left  = 0;
  int m_last  = 1;

  task automatic check(input string name, input logic [DB-1:0] act, input logic [DB-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [DB-1:0] rnd_data();
    return {$urandom(), $urandom(), $urandom(), $urandom()};
  endfunction

  function automatic req_t rnd_req();
    req_t r;
    r.rw   = 2'($urandom);
    r.addr = AB'($urandom);
    r.data = rnd_data();
    r.tag  = CT'($urandom);
    return r;
  endfunction

  task automatic push_load(input int k, input logic [AB-1:0] addr, input logic [CT-1:0] tag);
    req_t r;
    r.rw   = {1'($urandom), 1'b0};
    r.addr = addr;
    r.data = rnd_data();
    r.tag  = tag;
    pend[k].push_back(r);
  endtask

  task automatic push_burst(input int k, input logic [AB-1:0] base);
    req_t r;
    for (int b = 0; b < SB; b++) begin
      r.rw   = {1'($urandom), 1'b1};
      r.addr = base + AB'(b);
      r.data = rnd_data();
      r.tag  = CT'($urandom);
      pend[k].push_back(r);
    end
  endtask

  task automatic drive_client(input int k, input logic val, input req_t r);
    if (k == 0) begin
      c0_if.req_val = val; c0_if.req_rw = r.rw; c0_if.req_addr = r.addr;
      c0_if.req_data = r.data; c0_if.req_tag = r.tag;
    end else begin
      c1_if.req_val = val; c1_if.req_rw = r.rw; c1_if.req_addr = r.addr;
      c1_if.req_data = r.data; c1_if.req_tag = r.tag;
    end
  endtask

  task automatic drive_resp(input resp_t rs);
    mem_if.resp_val  = rs.val;
    mem_if.resp_nack = rs.nack;
    mem_if.resp_data = rs.data;
    mem_if.resp_tag  = rs.tag;
    if (rs.val) exp_resp_q.push_back({rs.tag[MT-1], rs.nack, rs.data, rs.tag[CT-1:0]});
  endtask

  // One clock of stimulus; the model decides who is presented and who fires.
  task automatic step(input int vprob, input int rprob, input int resp_prob);
    bit    v [2];
    req_t  cur [2];
    bit    rdy;
    int    win;
    resp_t rs;
    @(posedge clk);
    #1;
    reset_n = 1'b1;
    for (int k = 0; k < 2; k++) begin
      if (gen_en && pend[k].size() == 0 && $urandom_range(3) == 0) begin
        if ($urandom_range(2) == 0) push_burst(k, AB'($urandom) & ~AB'(SB - 1));
        else                        push_load(k, AB'($urandom), CT'($urandom));
      end
      v[k]   = (pend[k].size() > 0) && ($urandom_range(99) < vprob);
      cur[k] = v[k] ? pend[k][0] : rnd_req();
      drive_client(k, v[k], cur[k]);
    end
    rdy = ($urandom_range(99) < rprob);
    mem_if.req_rdy = rdy;

    if (m_owner >= 0)      win = m_owner;
    else if (v[0] && v[1]) win = 1 - m_last;
    else if (v[0])         win = 0;
    else if (v[1])         win = 1;
    else                   win = m_last;

    exp_rdy_q.push_back({win == 1 && rdy, win == 0 && rdy});
    if (v[win]) begin
      exp_req_q.push_back({1'(win), cur[win]});
      if (rdy) begin
        void'(pend[win].pop_front());
        if (m_owner >= 0) begin
          m_left--;
          if (m_left == 0) m_owner = -1;
        end else begin
          m_last = win;
          if (cur[win].rw[0]) begin
            m_owner = win;
            m_left  = SB - 1;
          end
        end
      end
    end

    if (resp_plan.size() > 0) rs = resp_plan.pop_front();
    else begin
      rs.val  = ($urandom_range(99) < resp_prob);
      rs.nack = rs.val & 1'($urandom);
      rs.data = rnd_data();
      rs.tag  = MT'($urandom);
    end
    drive_resp(rs);
  endtask

  // One clock with reset asserted: all queued work is discarded.
  task automatic reset_step();
    bit    rdy;
    resp_t rs;
    @(posedge clk);
    #1;
    reset_n = 1'b0;
    pend[0].delete();
    pend[1].delete();
    m_owner = -1;
    m_left  = 0;
    m_last  = 1;
    drive_client(0, 1'b0, rnd_req());
    drive_client(1, 1'b0, rnd_req());
    rdy = 1'($urandom);
    mem_if.req_rdy = rdy;
    exp_rdy_q.push_back({rdy, 1'b0});
    rs = '0;
    drive_resp(rs);
  endtask

  // Monitor: pops predictions and compares against what the DUT presents.
  logic [1:0] mon_rdy;
  exp_req_t   mon_req;
  exp_resp_t  mon_resp;

  always @(negedge clk) begin
    if (exp_rdy_q.size() > 0) begin
      mon_rdy = exp_rdy_q.pop_front();
      check("client_req_rdy", {c1_if.req_rdy, c0_if.req_rdy}, mon_rdy);
      if (mem_if.req_val) begin
        if (exp_req_q.size() == 0) check("mem_req_val", mem_if.req_val, 1'b0);
        else begin
          mon_req = exp_req_q.pop_front();
          check("mem_req_tag",  mem_if.req_tag,  {mon_req.id, mon_req.r.tag});
          check("mem_req_addr", mem_if.req_addr, mon_req.r.addr);
          check("mem_req_rw",   mem_if.req_rw,   mon_req.r.rw);
          check("mem_req_data", mem_if.req_data, mon_req.r.data);
        end
      end
      if (c0_if.resp_val) begin
        if (exp_resp_q.size() == 0) check("c0_resp_val", c0_if.resp_val, 1'b0);
        else begin
          mon_resp = exp_resp_q.pop_front();
          check("c0_resp_route", 1'b0, mon_resp.id);
          check("c0_resp_nack", c0_if.resp_nack, mon_resp.nack);
          check("c0_resp_tag",  c0_if.resp_tag,  mon_resp.tag);
          check("c0_resp_data", c0_if.resp_data, mon_resp.data);
        end
      end
      if (c1_if.resp_val) begin
        if (exp_resp_q.size() == 0) check("c1_resp_val", c1_if.resp_val, 1'b0);
        else begin
          mon_resp = exp_resp_q.pop_front();
          check("c1_resp_route", 1'b1, mon_resp.id);
          check("c1_resp_nack", c1_if.resp_nack, mon_resp.nack);
          check("c1_resp_tag",  c1_if.resp_tag,  mon_resp.tag);
          check("c1_resp_data", c1_if.resp_data, mon_resp.data);
        end
      end
    end
  end

  initial begin
    resp_t rs;
    drive_client(0, 1'b0, '0);
    drive_client(1, 1'b0, '0);
    mem_if.req_rdy = 1'b0;
    rs = '0;
    mem_if.resp_val = 1'b0; mem_if.resp_nack = 1'b0;
    mem_if.resp_data = '0;  mem_if.resp_tag = '0;
    repeat (2) reset_step();

    // Client 0 alone loads 0x010 tag 3, then four response beats come back to it.
    push_load(0, 12'h010, 4'h3);
    step(100, 100, 0);
    for (int b = 0; b < 4; b++) begin
      rs.val = 1'b1; rs.nack = 1'b0; rs.data = rnd_data(); rs.tag = 5'b0_0011;
      resp_plan.push_back(rs);
    end
    repeat (5) step(100, 100, 0);

    // Both clients load on the first cycle after reset: client 0 first.
    reset_step();
    push_load(0, AB'($urandom), 4'h1);
    push_load(1, AB'($urandom), 4'h2);
    repeat (3) step(100, 100, 0);

    // Client 1 store burst locks out client 0's pending load.
    push_load(0, AB'($urandom), CT'($urandom));
    push_load(0, AB'($urandom), CT'($urandom));
    push_burst(1, 12'h100);
    repeat (8) step(100, 100, 0);

    // L2 stalls for three cycles with both clients waiting.
    push_load(0, AB'($urandom), CT'($urandom));
    push_load(1, AB'($urandom), CT'($urandom));
    repeat (3) step(100, 0, 0);
    repeat (3) step(100, 100, 0);

    // Reset after two beats of a client 1 store burst.
    push_burst(1, 12'h200);
    repeat (2) step(100, 100, 0);
    reset_step();
    push_load(0, AB'($urandom), CT'($urandom));
    push_load(1, AB'($urandom), CT'($urandom));
    repeat (3) step(100, 100, 0);

    // Nacked response for client 1, tag 5'b1_0101.
    rs.val = 1'b1; rs.nack = 1'b1; rs.data = rnd_data(); rs.tag = 5'b1_0101;
    resp_plan.push_back(rs);
    repeat (2) step(0, 100, 0);

    // Random traffic in blocks with varying valid/ready/response densities.
    gen_en = 1'b1;
    for (int blk = 0; blk < 30; blk++) begin
      int vp, rp, qp;
      vp = $urandom_range(30, 100);
      rp = $urandom_range(20, 100);
      qp = $urandom_range(0, 80);
      if ($urandom_range(9) == 0) reset_step();
      repeat (100) step(vp, rp, qp);
    end

    gen_en = 1'b0;
    for (int i = 0; i < 200 && (pend[0].size() > 0 || pend[1].size() > 0); i++)
      step(100, 100, 0);
    repeat (2) step(0, 100, 0);
    @(negedge clk);
    #1;
    check("req_queue_drained",  exp_req_q.size(),  0);
    check("resp_queue_drained", exp_resp_q.size(), 0);
    check("rdy_queue_drained",  exp_rdy_q.size(),  0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
